// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: round-robin byte collector into a double-buffered SPI transmit frame.
// Latency: a granted byte lands in the fill bank at the grant edge. It reaches rd_data the cycle after the spi_done that swaps its frame in.
// Backpressure: while a complete frame waits for swap, gnt stays low and producers hold req/req_data.
// Ports: clk, rst (async, active-high); req/req_data/gnt on the producer side;
//        spi_done, rd_addr/rd_data on the shifter side; frame_ready, frame_seq, underrun_cnt as status.
// Build option: define FRAME_SEQ_HDR_EN to make byte 0 of every frame carry the sequence number.
module spi_frame_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_BYTES = 16,
  localparam int AW         = $clog2(FRAME_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic                 spi_done,
  input  logic [AW-1:0]        rd_addr,
  output logic [7:0]           rd_data,
  output logic                 frame_ready,
  output logic [7:0]           frame_seq,
  output logic [7:0]           underrun_cnt
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef FRAME_SEQ_HDR_EN
  // Byte 0 is reserved for the header, so producers start at index 1.
  localparam logic [AW-1:0] FIRST_POS = AW'(1);
`else
  localparam logic [AW-1:0] FIRST_POS = '0;
`endif
  localparam logic [AW-1:0] LAST_POS = AW'(FRAME_BYTES - 1);

  typedef enum logic {S_FILL, S_READY} state_t;
  state_t state_q, state_d;

  logic [FRAME_BYTES-1:0][7:0] bank [2];
  logic                        send_sel;
  logic                        fill_sel;
  logic [AW-1:0]               wr_ptr;
  logic [RW-1:0]               rr_ptr;
  logic [RW-1:0]               rr_nxt;
  logic [RW-1:0]               gnt_idx;
  logic [RW-1:0]               cand_idx;
  logic                        gnt_vld;
  logic [7:0]                  gnt_dat;
  int                          cand;
  logic                        xfer;
  logic                        swap;
  logic                        underrun;

  assign fill_sel    = ~send_sel;
  assign rd_data     = bank[send_sel][rd_addr];
  assign frame_ready = (state_q == S_READY);

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt      = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    if (!rst && state_q == S_FILL) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = cand[RW-1:0];
        if (!gnt_vld && req[cand_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand_idx;
        end
      end
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end
  end

  assign gnt_dat  = 8'(req_data >> {gnt_idx, 3'b000});
  assign rr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + RW'(1);
  assign xfer     = gnt_vld;
  assign swap     = spi_done && (state_q == S_READY);
  // A pulse on the same edge as the final fill byte still sees FILL and is an underrun.
  assign underrun = spi_done && (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (xfer && wr_ptr == LAST_POS) state_d = S_READY;
      S_READY: if (spi_done) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      bank[0]      <= '0;
      bank[1]      <= '0;
      send_sel     <= 1'b0;
      wr_ptr       <= FIRST_POS;
      rr_ptr       <= '0;
      frame_seq    <= 8'h00;
      underrun_cnt <= 8'h00;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        bank[fill_sel][wr_ptr] <= gnt_dat;
        wr_ptr                 <= wr_ptr + AW'(1);
        rr_ptr                 <= rr_nxt;
      end
      if (swap) begin
`ifdef FRAME_SEQ_HDR_EN
        // Stamp the outgoing frame with the sequence number it is published under.
        bank[fill_sel][0] <= frame_seq + 8'd1;
`endif
        send_sel  <= fill_sel;
        wr_ptr    <= FIRST_POS;
        frame_seq <= frame_seq + 8'd1;
      end
      if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
module tb_spi_frame_arbiter;
  localparam int NR = 4;
  localparam int FB = 16;
  localparam int AW = $clog2(FB);
`ifdef FRAME_SEQ_HDR_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            spi_done;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_data;
  logic            frame_ready;
  logic [7:0]      frame_seq;
  logic [7:0]      underrun_cnt;

  always #5 clk = ~clk;

  spi_frame_arbiter #(.NUM_REQ(NR), .FRAME_BYTES(FB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .spi_done(spi_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_seq(frame_seq), .underrun_cnt(underrun_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: two byte arrays, a fill position, a ready flag and counters.
  byte unsigned m_send[FB];
  byte unsigned m_fill[FB];
  int           m_pos, m_rr, m_seq, m_und;
  bit           m_ready;

  typedef struct {
    logic [NR-1:0] r;
    logic [NR-1:0] eg;
  } rr_vec_t;
  rr_vec_t tbl[10];

  int            g;
  logic [NR-1:0] dg;
  logic [NR-1:0] pr;
  logic [8*NR-1:0] pd;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < FB; i++) begin
      m_send[i] = 8'h00;
      m_fill[i] = 8'h00;
    end
    m_pos = FIRST; m_rr = 0; m_seq = 0; m_und = 0; m_ready = 0;
  endtask

  function automatic int m_grant(input logic [NR-1:0] r);
    logic [NR-1:0] sh;
    if (m_ready) return -1;
    for (int k = 0; k < NR; k++) begin
      sh = r >> ((m_rr + k) % NR);
      if (sh[0]) return (m_rr + k) % NR;
    end
    return -1;
  endfunction

  // One clock: drive at posedge+1, check mid-cycle, advance model at the edge.
  task automatic cycle(input logic [NR-1:0] r, input logic [8*NR-1:0] d, input logic done,
                       input int addr, output int gi, output logic [NR-1:0] dgi);
    logic [NR-1:0]   eg;
    logic [8*NR-1:0] sh;
    byte unsigned    tmp;
    bit              was_ready;
    req = r; req_data = d; spi_done = done; rd_addr = AW'(addr);
    #3;
    gi = m_grant(r);
    eg = '0;
    if (gi >= 0) eg = NR'(1) << gi;
    dgi = gnt;
    check("gnt", int'(gnt), int'(eg));
    check("rd_data", int'(rd_data), int'(m_send[addr]));
    check("frame_ready", int'(frame_ready), int'(m_ready));
    check("frame_seq", int'(frame_seq), m_seq);
    check("underrun_cnt", int'(underrun_cnt), m_und);
    @(posedge clk);
    was_ready = m_ready;
    if (gi >= 0) begin
      sh = d >> (8 * gi);
      m_fill[m_pos] = sh[7:0];
      m_pos++;
      m_rr = (gi + 1) % NR;
      if (m_pos == FB) m_ready = 1;
    end
    if (done) begin
      if (was_ready) begin
        if (FIRST == 1) m_fill[0] = 8'(m_seq + 1);
        for (int i = 0; i < FB; i++) begin
          tmp = m_send[i]; m_send[i] = m_fill[i]; m_fill[i] = tmp;
        end
        m_seq = (m_seq + 1) % 256;
        m_pos = FIRST;
        m_ready = 0;
      end else if (m_und < 255) begin
        m_und++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '1; req_data = '1; spi_done = 1'b1; rd_addr = '0;
    model_reset();
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_frame_seq", int'(frame_seq), 0);
    check("rst_underrun", int'(underrun_cnt), 0);
    for (int a = 0; a < FB; a++) begin
      rd_addr = AW'(a);
      #1;
      check("rst_rd_data", int'(rd_data), 0);
    end
    @(posedge clk);
    #1;
    req = '0; spi_done = 1'b0; rst = 1'b0;
  endtask

  // Producer 0 supplies base, base+1, ... one byte per cycle.
  task automatic push(input int n, input int base);
    logic [8*NR-1:0] d;
    int              gg;
    logic [NR-1:0]   dd;
    for (int i = 0; i < n; i++) begin
      d = '0;
      d[7:0] = 8'(base + i);
      cycle(NR'(1), d, 1'b0, i % FB, gg, dd);
    end
  endtask

  task automatic pulse();
    int            gg;
    logic [NR-1:0] dd;
    cycle('0, '0, 1'b1, 0, gg, dd);
  endtask

  task automatic read_chk(input string name, input int addr, input int exp);
    rd_addr = AW'(addr);
    #1;
    check(name, int'(rd_data), exp);
  endtask

  initial begin
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b1111, 4'b0100};
    tbl[3] = '{4'b1111, 4'b1000};
    tbl[4] = '{4'b1010, 4'b0010};
    tbl[5] = '{4'b1010, 4'b1000};
    tbl[6] = '{4'b0000, 4'b0000};
    tbl[7] = '{4'b0100, 4'b0100};
    tbl[8] = '{4'b0001, 4'b0001};
    tbl[9] = '{4'b1001, 4'b1000};

    // Single producer fills a frame, then swap exposes it.
    do_reset();
    push(FB - FIRST, 1);
    check("t1_ready", int'(frame_ready), 1);
    pulse();
    check("t1_seq", int'(frame_seq), 1);
    check("t1_ready_after", int'(frame_ready), 0);
    for (int a = 0; a < FB; a++) read_chk("t1_rd", a, (a < FIRST) ? 1 : a - FIRST + 1);

    // Round-robin order from a table of request patterns.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, 32'h44332211, 1'b0, 0, g, dg);
      check("rr_tbl", int'(dg), int'(tbl[i].eg));
    end
    do_reset();
    for (int i = 0; i < FB - FIRST; i++) cycle('1, 32'h44332211, 1'b0, 0, g, dg);
    pulse();
    for (int a = FIRST; a < FB; a++) read_chk("t2_rd", a, 8'h11 * (((a - FIRST) % 4) + 1));

    // Early spi_done: underrun, no swap, fill progress kept.
    do_reset();
    push(5, 8'h20);
    pulse();
    check("t3_underrun", int'(underrun_cnt), 1);
    check("t3_seq", int'(frame_seq), 0);
    read_chk("t3_rd0", 0, 0);
    read_chk("t3_rd3", 3, 0);
    push(FB - FIRST - 5, 8'h25);
    check("t3_ready", int'(frame_ready), 1);
    pulse();
    check("t3_seq_after", int'(frame_seq), 1);
    read_chk("t3_first", FIRST, 8'h20);
    read_chk("t3_sixth", FIRST + 5, 8'h25);

    // Last byte and spi_done on the same edge.
    do_reset();
    push(FB - FIRST - 1, 8'h50);
    begin
      logic [8*NR-1:0] d;
      d = '0;
      d[7:0] = 8'(8'h50 + FB - FIRST - 1);
      cycle(NR'(1), d, 1'b1, 0, g, dg);
    end
    check("t4_underrun", int'(underrun_cnt), 1);
    check("t4_ready", int'(frame_ready), 1);
    pulse();
    check("t4_seq", int'(frame_seq), 1);
    check("t4_ready_after", int'(frame_ready), 0);
    read_chk("t4_last", FB - 1, 8'h50 + FB - FIRST - 1);

    // Underrun counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) pulse();
    check("t5_underrun", int'(underrun_cnt), 255);
    check("t5_seq", int'(frame_seq), 0);

    // Reset mid-fill after three swaps.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push(FB - FIRST, 8'h60 + 16 * f);
      pulse();
    end
    check("t6_seq3", int'(frame_seq), 3);
    push(9, 8'h90);
    do_reset();
    push(FB - FIRST, 8'hA0);
    pulse();
    check("t6_seq_post", int'(frame_seq), 1);
    read_chk("t6_rd0", 0, (FIRST == 1) ? 1 : 8'hA0);

    // Randomised traffic against the model.
    do_reset();
    pr = '0;
    pd = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ((pr & (NR'(1) << i)) == '0 && $urandom_range(0, 2) == 0) begin
          pr = pr | (NR'(1) << i);
          pd = (pd & ~({{(8*NR-8){1'b0}}, 8'hFF} << (8 * i)))
             | ({{(8*NR-8){1'b0}}, 8'($urandom)} << (8 * i));
        end
      end
      cycle(pr, pd, ($urandom_range(0, 7) == 0), $urandom_range(0, FB - 1), g, dg);
      if (g >= 0) pr = pr & ~(NR'(1) << g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
